mult_issue: RTL and testbench

MULT_ISSUE -- requirements
Module: mult_issue

---
 rtl/mult_pkg.sv | 26 ++
 rtl/mult_issue_fifo.sv | 63 ++++++
 rtl/mult_issue.sv | 161 ++++++++++++++++
 tb/tb_mult_issue.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the multiplier issue block: completion status codes, FSM states and queue entry.
package mult_pkg;

  localparam int DEFAULT_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    OK          = 2'b00,
    ARG_ERR     = 2'b01,
    RES_PAR_ERR = 2'b10,
    TIMEOUT     = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RES,
    OUT
  } state_e;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  inj;
  } pair_t;

endpackage

// File: rtl/mult_issue_fifo.sv
// Operand-pair queue: registered read port, push refused when full, pop refused when empty.
// Simultaneous push and pop keep the count; pointers wrap modulo DEPTH.
module mult_issue_fifo
  import mult_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  pair_t dat_i,
  input  logic  pop_i,
  output pair_t dat_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  pair_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dat_o   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= dat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mult_issue.sv
// Queues signed operand pairs and issues them one at a time to a req/ack multiplier; req rises the cycle after the pop.
// in_ready drops when the queue is full; a completed result is held on out_* until out_ready, with a per-phase timeout.
module mult_issue
  import mult_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [1:0]  in_inj_err,
  output logic        req,
  input  logic        ack,
  output logic [15:0] arg_a,
  output logic        arg_a_parity,
  output logic [15:0] arg_b,
  output logic        arg_b_parity,
  input  logic        result_rdy,
  input  logic [31:0] result,
  input  logic        result_parity,
  input  logic        arg_parity_error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [1:0]  out_status
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e        state_q, state_d;
  pair_t         fifo_wr_dat, fifo_rd_dat;
  logic          fifo_full, fifo_empty, push, pop;
  logic [15:0]   arg_a_q, arg_a_d, arg_b_q, arg_b_d;
  logic          arg_a_par_q, arg_a_par_d, arg_b_par_q, arg_b_par_d;
  logic [31:0]   out_result_q, out_result_d;
  status_e       out_status_q, out_status_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;

  assign in_ready    = !fifo_full;
  assign push        = in_valid && in_ready;
  assign fifo_wr_dat = '{a: in_a, b: in_b, inj: in_inj_err};

  mult_issue_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .dat_i   (fifo_wr_dat),
    .pop_i   (pop),
    .dat_o   (fifo_rd_dat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The counter would reach TIMEOUT_CYC on this edge, so the phase has lasted TIMEOUT_CYC cycles.
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    arg_a_d      = arg_a_q;
    arg_b_d      = arg_b_q;
    arg_a_par_d  = arg_a_par_q;
    arg_b_par_d  = arg_b_par_q;
    out_result_d = out_result_q;
    out_status_d = out_status_q;
    tmo_d        = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = REQ;
          tmo_d   = '0;
        end
      end
      REQ: begin
        tmo_d = tmo_q + 1'b1;
        if (ack) begin
          state_d = WAIT_RES;
          tmo_d   = '0;
        end else if (tmo_hit) begin
          state_d      = OUT;
          out_result_d = '0;
          out_status_d = TIMEOUT;
        end
      end
      WAIT_RES: begin
        tmo_d = tmo_q + 1'b1;
        if (result_rdy) begin
          state_d      = OUT;
          out_result_d = result;
          if (arg_parity_error)             out_status_d = ARG_ERR;
          else if (^result != result_parity) out_status_d = RES_PAR_ERR;
          else                               out_status_d = OK;
        end else if (tmo_hit) begin
          state_d      = OUT;
          out_result_d = '0;
          out_status_d = TIMEOUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = REQ;
            tmo_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      arg_a_d     = fifo_rd_dat.a;
      arg_b_d     = fifo_rd_dat.b;
      arg_a_par_d = ^fifo_rd_dat.a ^ fifo_rd_dat.inj[0];
      arg_b_par_d = ^fifo_rd_dat.b ^ fifo_rd_dat.inj[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      arg_a_q      <= '0;
      arg_b_q      <= '0;
      arg_a_par_q  <= 1'b0;
      arg_b_par_q  <= 1'b0;
      out_result_q <= '0;
      out_status_q <= OK;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      arg_a_q      <= arg_a_d;
      arg_b_q      <= arg_b_d;
      arg_a_par_q  <= arg_a_par_d;
      arg_b_par_q  <= arg_b_par_d;
      out_result_q <= out_result_d;
      out_status_q <= out_status_d;
      tmo_q        <= tmo_d;
    end
  end

  assign req          = (state_q == REQ);
  assign out_valid    = (state_q == OUT);
  assign arg_a        = arg_a_q;
  assign arg_b        = arg_b_q;
  assign arg_a_parity = arg_a_par_q;
  assign arg_b_parity = arg_b_par_q;
  assign out_result   = out_result_q;
  assign out_status   = out_status_q;

endmodule

// File: tb/tb_mult_issue.sv
// Directed and randomized bench for mult_issue: a multiplier responder and a downstream consumer
// run alongside a transaction-level model that predicts each completion from the pushed operands.
module tb_mult_issue;

  localparam int TMO      = 255;
  localparam int M_OK     = 0;
  localparam int M_RESPAR = 1;
  localparam int M_NOACK  = 2;
  localparam int M_NORES  = 3;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  inj;
    int          mode;
    logic [31:0] res;
    logic [1:0]  st;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [1:0]  in_inj_err = '0;
  logic        ack = 1'b0;
  logic        result_rdy = 1'b0;
  logic [31:0] result = '0;
  logic        result_parity = 1'b0;
  logic        arg_parity_error = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, req, arg_a_parity, arg_b_parity, out_valid;
  logic [15:0] arg_a, arg_b;
  logic [31:0] out_result;
  logic [1:0]  out_status;

  bit   hold_ready = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  txn_t exp_q[$];
  txn_t rsp_q[$];

  always #5 clk = ~clk;

  mult_issue #(
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_a             (in_a),
    .in_b             (in_b),
    .in_inj_err       (in_inj_err),
    .req              (req),
    .ack              (ack),
    .arg_a            (arg_a),
    .arg_a_parity     (arg_a_parity),
    .arg_b            (arg_b),
    .arg_b_parity     (arg_b_parity),
    .result_rdy       (result_rdy),
    .result           (result),
    .result_parity    (result_parity),
    .arg_parity_error (arg_parity_error),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_status       (out_status)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Expected completion: timeouts report zero/11, otherwise the true product with argument errors outranking result parity.
  function automatic txn_t make_txn(input logic [15:0] a, input logic [15:0] b,
                                    input logic [1:0] inj, input int mode);
    txn_t t;
    int   p;
    p      = int'($signed(a)) * int'($signed(b));
    t.a    = a;
    t.b    = b;
    t.inj  = inj;
    t.mode = mode;
    if (mode == M_NOACK || mode == M_NORES) begin
      t.res = '0;
      t.st  = 2'd3;
    end else begin
      t.res = 32'(p);
      if (inj != 2'b00)         t.st = 2'd1;
      else if (mode == M_RESPAR) t.st = 2'd2;
      else                       t.st = 2'd0;
    end
    return t;
  endfunction

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [1:0] inj, input int mode);
    int w;
    in_a       = a;
    in_b       = b;
    in_inj_err = inj;
    in_valid   = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!in_ready && w < 3000);
    check("push_in_ready", in_ready, 1);
    if (in_ready) begin
      @(posedge clk);
      #1;
      exp_q.push_back(make_txn(a, b, inj, mode));
      rsp_q.push_back(make_txn(a, b, inj, mode));
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", in_ready, 1);
    check("rst_req", req, 0);
    check("rst_arg_a", arg_a, 0);
    check("rst_arg_b", arg_b, 0);
    check("rst_arg_a_par", arg_a_parity, 0);
    check("rst_arg_b_par", arg_b_parity, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_status", out_status, 0);
  endtask

  // Behaves as the multiplier: acks after a random delay, returns the product of what it was given.
  task automatic responder();
    txn_t t;
    int   n;
    int   p;
    forever begin
      if (req && rsp_q.size() == 0) begin
        check("req_without_txn", rsp_q.size(), 1);
        @(posedge clk);
        #1;
      end else if (req) begin
        t = rsp_q.pop_front();
        check("arg_a", arg_a, t.a);
        check("arg_b", arg_b, t.b);
        check("arg_a_par", arg_a_parity, (^t.a) ^ t.inj[0]);
        check("arg_b_par", arg_b_parity, (^t.b) ^ t.inj[1]);
        if (t.mode == M_NOACK) begin
          n = 0;
          while (req && n < TMO + 20) begin
            n++;
            @(posedge clk);
            #1;
          end
          check("req_cycles_to_timeout", n, TMO);
        end else begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          check("req_held", req, 1);
          check("arg_a_stable", arg_a, t.a);
          ack = 1'b1;
          @(posedge clk);
          #1;
          ack = 1'b0;
          check("req_drop_after_ack", req, 0);
          if (t.mode != M_NORES) begin
            repeat ($urandom_range(0, 3)) begin
              @(posedge clk);
              #1;
            end
            p                = int'(shortint'(arg_a)) * int'(shortint'(arg_b));
            result           = 32'(p);
            result_parity    = (^p) ^ (t.mode == M_RESPAR);
            arg_parity_error = (^arg_a != arg_a_parity) || (^arg_b != arg_b_parity);
            result_rdy       = 1'b1;
            @(posedge clk);
            #1;
            check("out_valid_after_result", out_valid, 1);
            // Stray handshakes while the completion is parked must change nothing.
            result_rdy       = 1'($urandom_range(0, 1));
            ack              = 1'($urandom_range(0, 1));
            result           = $urandom;
            result_parity    = 1'($urandom_range(0, 1));
            arg_parity_error = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            result_rdy       = 1'b0;
            ack              = 1'b0;
            arg_parity_error = 1'b0;
          end
        end
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic consumer();
    txn_t e;
    forever begin
      @(posedge clk);
      #2;
      out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_valid_with_empty_model", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("out_result", out_result, e.res);
          check("out_status", out_status, e.st);
        end
      end
    end
  endtask

  initial begin
    int n;
    int r;
    int mode;
    logic [1:0] inj;

    #12;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fork
      responder();
      consumer();
    join_none

    push(16'd3, 16'hFFFE, 2'b00, M_OK);     drain();
    push(16'h0001, 16'h0009, 2'b01, M_OK);  drain();
    push(16'd5, 16'd7, 2'b00, M_RESPAR);    drain();
    push(16'd5, 16'd7, 2'b10, M_RESPAR);    drain();
    push(16'h8000, 16'h8000, 2'b00, M_OK);  drain();
    push(16'h7FFF, 16'h8000, 2'b00, M_OK);  drain();
    push(16'h1234, 16'h4321, 2'b00, M_NOACK); drain();

    hold_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) push(16'($urandom), 16'($urandom), 2'b00, M_OK);
    check("in_ready_when_full", in_ready, 0);
    repeat (20) @(posedge clk);
    #1;
    check("in_ready_stalled", in_ready, 0);
    check("out_valid_stalled", out_valid, 1);
    check("pending_while_stalled", exp_q.size(), 5);
    hold_ready = 1'b0;
    drain();

    push(16'h1234, 16'h00FF, 2'b00, M_NORES);
    n = 0;
    while (!req && n < 50) begin @(posedge clk); #1; n++; end
    while (req && n < 50) begin @(posedge clk); #1; n++; end
    repeat (5) @(posedge clk);
    #1;
    check("waiting_for_result", out_valid, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (3) @(posedge clk);
    #1;
    check("no_out_after_reset", out_valid, 0);
    rst_n = 1'b1;
    push(16'hFFFF, 16'hFFFF, 2'b00, M_OK);  drain();

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 99);
      mode = (r < 60) ? M_OK : (r < 85) ? M_RESPAR : (r < 93) ? M_NORES : M_NOACK;
      inj  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      push(16'($urandom), 16'($urandom), inj, mode);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
